exu_bru_pipe: RTL and testbench

Parametrised, registered successor of the combinational branch/jump resolution unit.
- Resolves branches, JAL/JALR and FENCE redirects in one pipeline stage behind a valid/ready handshake.
- Detects direction mispredicts and JALR target mispredicts.
- Queues BTB updates in an internal FIFO so a busy BTB write port never drops an update.
- Sits in EXU between dispatch and the IFU redirect/BTB ports.

---
 rtl/bru_pkg.sv | 32 +++
 rtl/exu_bru_pipe_if.sv | 58 +++++
 rtl/bru_btb_fifo.sv | 62 ++++++
 rtl/exu_bru_pipe.sv | 171 +++++++++++++++++
 tb/tb_exu_bru_pipe.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolution pipe: op encoding, BTB update record, fall-through size.
// No logic; latency n/a; backpressure n/a.
package bru_pkg;

    localparam int BRU_ADDR_W = 32;

    localparam int BRU_FALLTHRU = 4;

    typedef enum logic [3:0] {
        BRU_NONE  = 4'd0,
        BRU_BEQ   = 4'd1,
        BRU_BNE   = 4'd2,
        BRU_BLT   = 4'd3,
        BRU_BGE   = 4'd4,
        BRU_BLTU  = 4'd5,
        BRU_BGEU  = 4'd6,
        BRU_JAL   = 4'd7,
        BRU_JALR  = 4'd8,
        BRU_FENCE = 4'd9
    } bru_op_e;

    typedef struct packed {
        logic [BRU_ADDR_W-1:0] pc;
        logic [BRU_ADDR_W-1:0] target;
    } btb_upd_t;

    function automatic logic is_cond_branch(input bru_op_e op);
        return (op == BRU_BEQ)  || (op == BRU_BNE)  || (op == BRU_BLT) ||
               (op == BRU_BGE)  || (op == BRU_BLTU) || (op == BRU_BGEU);
    endfunction

endpackage

// File: rtl/exu_bru_pipe_if.sv
// Dispatch-side request, IFU redirect and BTB update bundle for exu_bru_pipe.
// No logic; latency n/a; backpressure carried by req_ready_o and btb_ready_i.
// Perf counter outputs exist only under BRU_PERF_CNT_EN.
interface exu_bru_pipe_if
    import bru_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    bru_op_e           op_i;
    logic [XLEN-1:0]   op1_i;
    logic [XLEN-1:0]   op2_i;
    logic [ADDR_W-1:0] jmp_op1_i;
    logic [ADDR_W-1:0] jmp_op2_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              pred_taken_i;
    logic              pred_jalr_i;
    logic [ADDR_W-1:0] pred_addr_i;
    logic              flush_i;
    logic              int_assert_i;
    logic [ADDR_W-1:0] int_addr_i;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              mispred_o;
    logic              btb_valid_o;
    logic              btb_ready_i;
    logic [ADDR_W-1:0] btb_pc_o;
    logic [ADDR_W-1:0] btb_target_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]       perf_branch_cnt_o;
    logic [31:0]       perf_mispred_cnt_o;
`endif

    modport master (
`ifdef BRU_PERF_CNT_EN
        input  perf_branch_cnt_o, perf_mispred_cnt_o,
`endif
        output req_valid_i, op_i, op1_i, op2_i, jmp_op1_i, jmp_op2_i, inst_addr_i,
               pred_taken_i, pred_jalr_i, pred_addr_i, flush_i, int_assert_i,
               int_addr_i, btb_ready_i,
        input  req_ready_o, jump_flag_o, jump_addr_o, mispred_o,
               btb_valid_o, btb_pc_o, btb_target_o
    );

    modport slave (
`ifdef BRU_PERF_CNT_EN
        output perf_branch_cnt_o, perf_mispred_cnt_o,
`endif
        input  req_valid_i, op_i, op1_i, op2_i, jmp_op1_i, jmp_op2_i, inst_addr_i,
               pred_taken_i, pred_jalr_i, pred_addr_i, flush_i, int_assert_i,
               int_addr_i, btb_ready_i,
        output req_ready_o, jump_flag_o, jump_addr_o, mispred_o,
               btb_valid_o, btb_pc_o, btb_target_o
    );

endinterface

// File: rtl/bru_btb_fifo.sv
// Generic synchronous FIFO with occupancy count, full and empty flags.
// Latency: a pushed entry is visible at the head the next cycle.
// Backpressure: pushes while full are dropped; caller must not push when full.
module bru_btb_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0],
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  T                 push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output T                 head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head_vld = ~empty;
    assign head_dat = mem[rd_ptr];
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & ~empty;

    // Storage is not reset; consumers qualify head_dat with head_vld.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exu_bru_pipe.sv
// Registered branch/jump/FENCE resolution with IFU redirect and a queued BTB update path.
// Latency 1 (accept -> redirect); interrupts redirect combinationally in the same cycle.
// Backpressure: req_ready_o reserves FIFO room for the stage; BTB stalls only fill the FIFO.
// Optional BRU_PERF_CNT_EN adds saturating branch / mispredict counters. rst_n is active-high.
module exu_bru_pipe
    import bru_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = BRU_ADDR_W,
    parameter int ILEN_BYTES = BRU_FALLTHRU,
    parameter int BTBQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    exu_bru_pipe_if.slave  bru
);

    localparam int CNT_W = $clog2(BTBQ_DEPTH + 1);

    typedef struct packed {
        bru_op_e           op;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [ADDR_W-1:0] jmp_op1;
        logic [ADDR_W-1:0] jmp_op2;
        logic [ADDR_W-1:0] inst_addr;
        logic [ADDR_W-1:0] pred_addr;
        logic              pred_taken;
        logic              pred_jalr;
    } stage_t;

    logic              rst;
    stage_t            stg_q;
    logic              stg_vld_q;
    logic              cond;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] fallthru;
    logic              rollback;
    logic              mismatch;
    logic              redirect;
    logic              kill;
    logic              resolve;
    logic              push_pending;
    logic              btb_push;
    logic              accept;
    btb_upd_t          push_dat;
    btb_upd_t          head_dat;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;

    assign rst = rst_n;

    always_comb begin
        cond = 1'b0;
        case (stg_q.op)
            BRU_BEQ:   cond = (stg_q.op1 == stg_q.op2);
            BRU_BNE:   cond = (stg_q.op1 != stg_q.op2);
            BRU_BLT:   cond = ($signed(stg_q.op1) <  $signed(stg_q.op2));
            BRU_BGE:   cond = ($signed(stg_q.op1) >= $signed(stg_q.op2));
            BRU_BLTU:  cond = (stg_q.op1 <  stg_q.op2);
            BRU_BGEU:  cond = (stg_q.op1 >= stg_q.op2);
            BRU_JAL,
            BRU_JALR,
            BRU_FENCE: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
    end

    assign tgt      = stg_q.jmp_op1 + stg_q.jmp_op2;
    assign fallthru = stg_q.inst_addr + ADDR_W'(ILEN_BYTES);
    assign rollback = stg_q.pred_taken & ~cond;
    assign mismatch = stg_q.pred_jalr & (tgt != stg_q.pred_addr);
    assign redirect = (cond & ~stg_q.pred_taken) | rollback | mismatch |
                      (stg_q.op == BRU_FENCE);

    assign kill    = bru.flush_i | bru.int_assert_i;
    assign resolve = stg_vld_q & ~kill;

    // The reservation looks only at stage contents so ready has no path from interrupts.
    assign push_pending = stg_vld_q & (stg_q.op == BRU_JALR) &
                          (~stg_q.pred_jalr | mismatch);
    assign btb_push     = push_pending & ~kill;

    assign bru.req_ready_o = ~bru.flush_i & ~fifo_full &
                             ((fifo_cnt < CNT_W'(BTBQ_DEPTH - 1)) |
                              ((fifo_cnt == CNT_W'(BTBQ_DEPTH - 1)) & ~push_pending));
    assign accept = bru.req_valid_i & bru.req_ready_o;

    always_comb begin
        bru.jump_flag_o = 1'b0;
        bru.jump_addr_o = '0;
        bru.mispred_o   = 1'b0;
        if (!rst) begin
            if (bru.int_assert_i) begin
                bru.jump_flag_o = 1'b1;
                bru.jump_addr_o = bru.int_addr_i;
            end else if (resolve && redirect) begin
                bru.jump_flag_o = 1'b1;
                bru.jump_addr_o = rollback ? fallthru : tgt;
                bru.mispred_o   = rollback | mismatch;
            end
        end
    end

    // Stage is single-use: it holds a request for exactly one cycle unless refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
        end else begin
            stg_vld_q <= accept;
            if (accept) begin
                stg_q.op         <= bru.op_i;
                stg_q.op1        <= bru.op1_i;
                stg_q.op2        <= bru.op2_i;
                stg_q.jmp_op1    <= bru.jmp_op1_i;
                stg_q.jmp_op2    <= bru.jmp_op2_i;
                stg_q.inst_addr  <= bru.inst_addr_i;
                stg_q.pred_addr  <= bru.pred_addr_i;
                stg_q.pred_taken <= bru.pred_taken_i;
                stg_q.pred_jalr  <= bru.pred_jalr_i;
            end
        end
    end

    assign push_dat.pc     = stg_q.inst_addr;
    assign push_dat.target = tgt;

    bru_btb_fifo #(
        .DEPTH (BTBQ_DEPTH),
        .T     (btb_upd_t)
    ) u_btb_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (btb_push),
        .push_dat (push_dat),
        .pop_rdy  (bru.btb_ready_i),
        .head_vld (bru.btb_valid_o),
        .head_dat (head_dat),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bru.btb_pc_o     = fifo_empty ? '0 : head_dat.pc;
    assign bru.btb_target_o = fifo_empty ? '0 : head_dat.target;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve && is_cond_branch(stg_q.op) && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (bru.mispred_o && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bru.perf_branch_cnt_o  = branch_cnt_q;
    assign bru.perf_mispred_cnt_o = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_exu_bru_pipe.sv
// Directed bench for exu_bru_pipe: vector table plus flush, interrupt, FIFO-fill and reset sequences.
module tb_exu_bru_pipe;
    import bru_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    exu_bru_pipe_if #(.XLEN(32), .ADDR_W(32)) bif ();

    exu_bru_pipe #(
        .XLEN(32), .ADDR_W(32), .ILEN_BYTES(4), .BTBQ_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bru   (bif)
    );

    typedef struct {
        bru_op_e     op;
        logic [31:0] op1, op2, jo1, jo2, pc, pa;
        logic        pt, pj;
        logic        e_flag;
        logic [31:0] e_addr;
        logic        e_mis, e_push;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bif.req_valid_i  = 1'b0;
        bif.op_i         = BRU_NONE;
        bif.op1_i        = '0;
        bif.op2_i        = '0;
        bif.jmp_op1_i    = '0;
        bif.jmp_op2_i    = '0;
        bif.inst_addr_i  = '0;
        bif.pred_taken_i = 1'b0;
        bif.pred_jalr_i  = 1'b0;
        bif.pred_addr_i  = '0;
        bif.flush_i      = 1'b0;
        bif.int_assert_i = 1'b0;
        bif.int_addr_i   = '0;
        bif.btb_ready_i  = 1'b1;
    endtask

    task automatic drive(input bru_op_e op, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] jo1, input logic [31:0] jo2, input logic [31:0] pc,
                         input logic [31:0] pa, input logic pt, input logic pj);
        bif.req_valid_i  = 1'b1;
        bif.op_i         = op;
        bif.op1_i        = op1;
        bif.op2_i        = op2;
        bif.jmp_op1_i    = jo1;
        bif.jmp_op2_i    = jo2;
        bif.inst_addr_i  = pc;
        bif.pred_addr_i  = pa;
        bif.pred_taken_i = pt;
        bif.pred_jalr_i  = pj;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        //              op         op1           op2   jo1           jo2     pc            pa        pt pj  flag addr         mis push
        vecs[0]  = '{BRU_BEQ,   32'h5,        32'h5, 32'h100,      32'h20, 32'h40,       32'h0,    0, 0, 1, 32'h120,     0, 0};
        vecs[1]  = '{BRU_BLT,   32'hFFFFFFFF, 32'h1, 32'h100,      32'h0,  32'h200,      32'h0,    1, 0, 0, 32'h0,       0, 0};
        vecs[2]  = '{BRU_BLTU,  32'hFFFFFFFF, 32'h1, 32'h100,      32'h0,  32'h200,      32'h0,    1, 0, 1, 32'h204,     1, 0};
        vecs[3]  = '{BRU_JALR,  32'h0,        32'h0, 32'h3000,     32'h4,  32'h500,      32'h3000, 1, 1, 1, 32'h3004,    1, 1};
        vecs[4]  = '{BRU_BNE,   32'h1,        32'h2, 32'h10,       32'h10, 32'h60,       32'h0,    0, 0, 1, 32'h20,      0, 0};
        vecs[5]  = '{BRU_BGE,   32'hFFFFFFFF, 32'h1, 32'h0,        32'h0,  32'h1000,     32'h0,    1, 0, 1, 32'h1004,    1, 0};
        vecs[6]  = '{BRU_BGEU,  32'hFFFFFFFF, 32'h1, 32'h80,       32'h0,  32'h70,       32'h0,    0, 0, 1, 32'h80,      0, 0};
        vecs[7]  = '{BRU_JAL,   32'h0,        32'h0, 32'h800,      32'h4,  32'h74,       32'h0,    1, 0, 0, 32'h0,       0, 0};
        vecs[8]  = '{BRU_JALR,  32'h0,        32'h0, 32'h4000,     32'h0,  32'h78,       32'h4000, 1, 1, 0, 32'h0,       0, 0};
        vecs[9]  = '{BRU_JALR,  32'h0,        32'h0, 32'h6F0,      32'h10, 32'h600,      32'h0,    0, 0, 1, 32'h700,     0, 1};
        vecs[10] = '{BRU_FENCE, 32'h0,        32'h0, 32'h900,      32'h0,  32'h88,       32'h0,    1, 0, 1, 32'h900,     0, 0};
        vecs[11] = '{BRU_BEQ,   32'h1,        32'h2, 32'h0,        32'h0,  32'hFFFFFFFC, 32'h0,    1, 0, 1, 32'h0,       1, 0};
        vecs[12] = '{BRU_BEQ,   32'h3,        32'h3, 32'hFFFFFFF0, 32'h20, 32'h90,       32'h0,    0, 0, 1, 32'h10,      0, 0};
        vecs[13] = '{BRU_NONE,  32'h0,        32'h0, 32'h0,        32'h0,  32'h94,       32'h0,    0, 0, 0, 32'h0,       0, 0};

        // Reset state
        #1;
        chk("rst_ready", bif.req_ready_o, 1);
        chk("rst_flag", bif.jump_flag_o, 0);
        chk("rst_addr", bif.jump_addr_o, 0);
        chk("rst_mis", bif.mispred_o, 0);
        chk("rst_btb_vld", bif.btb_valid_o, 0);
        chk("rst_btb_pc", bif.btb_pc_o, 0);
        #11 rst_n = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].op1, vecs[i].op2, vecs[i].jo1, vecs[i].jo2,
                  vecs[i].pc, vecs[i].pa, vecs[i].pt, vecs[i].pj);
            #1 chk($sformatf("v%0d_ready", i), bif.req_ready_o, 1);
            tick();
            bif.req_valid_i = 1'b0;
            #1;
            chk($sformatf("v%0d_flag", i), bif.jump_flag_o, vecs[i].e_flag);
            chk($sformatf("v%0d_addr", i), bif.jump_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_mis", i), bif.mispred_o, vecs[i].e_mis);
            tick();
            chk($sformatf("v%0d_once", i), bif.jump_flag_o, 0);
            chk($sformatf("v%0d_push", i), bif.btb_valid_o, vecs[i].e_push);
            if (vecs[i].e_push) begin
                chk($sformatf("v%0d_btb_pc", i), bif.btb_pc_o, vecs[i].pc);
                chk($sformatf("v%0d_btb_tgt", i), bif.btb_target_o, vecs[i].e_addr);
            end
            tick();
            chk($sformatf("v%0d_popped", i), bif.btb_valid_o, 0);
        end

        // Flush kills the stage and blocks a same-cycle request
        drive(BRU_BEQ, 32'h5, 32'h5, 32'h100, 32'h20, 32'h40, 32'h0, 0, 0);
        tick();
        bif.flush_i = 1'b1;
        drive(BRU_BEQ, 32'h7, 32'h7, 32'h200, 32'h20, 32'h44, 32'h0, 0, 0);
        #1;
        chk("flush_kill", bif.jump_flag_o, 0);
        chk("flush_gate", bif.req_ready_o, 0);
        tick();
        bif.flush_i = 1'b0;
        bif.req_valid_i = 1'b0;
        #1 chk("flush_no_accept", bif.jump_flag_o, 0);
        tick();

        // Interrupt overrides a mispredicted JALR and suppresses its BTB push
        drive(BRU_JALR, 32'h0, 32'h0, 32'h3000, 32'h4, 32'h500, 32'h3000, 1, 1);
        tick();
        bif.req_valid_i  = 1'b0;
        bif.int_assert_i = 1'b1;
        bif.int_addr_i   = 32'h80;
        #1;
        chk("int_flag", bif.jump_flag_o, 1);
        chk("int_addr", bif.jump_addr_o, 32'h80);
        chk("int_mis", bif.mispred_o, 0);
        tick();
        bif.int_assert_i = 1'b0;
        #1;
        chk("int_single_pulse", bif.jump_flag_o, 0);
        chk("int_no_push", bif.btb_valid_o, 0);
        tick();

        // BTB stalled: fill with unpredicted JALRs until ready drops
        bif.btb_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(BRU_JALR, 32'h0, 32'h0, 32'h1000, 32'(k), 32'h100 + 32'(k * 16), 32'h0, 0, 0);
            #1 chk($sformatf("fill%0d_ready", k), bif.req_ready_o, 1);
            tick();
        end
        drive(BRU_JALR, 32'h0, 32'h0, 32'h1000, 32'h4, 32'h140, 32'h0, 0, 0);
        #1 chk("fill_reserve_ready", bif.req_ready_o, 0);
        tick();
        chk("fill_full_ready", bif.req_ready_o, 0);
        chk("fill_btb_vld", bif.btb_valid_o, 1);
        bif.req_valid_i = 1'b0;
        bif.btb_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d_vld", k), bif.btb_valid_o, 1);
            chk($sformatf("drain%0d_pc", k), bif.btb_pc_o, 32'h100 + 32'(k * 16));
            chk($sformatf("drain%0d_tgt", k), bif.btb_target_o, 32'h1000 + 32'(k));
            tick();
        end
        chk("drain_empty", bif.btb_valid_o, 0);
        chk("drain_ready", bif.req_ready_o, 1);

        // Reset with 3 FIFO entries and a redirecting JALR in the stage
        bif.btb_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(BRU_JALR, 32'h0, 32'h0, 32'h2000, 32'(k), 32'h300 + 32'(k * 4), 32'h0, 0, 0);
            tick();
        end
        bif.req_valid_i = 1'b0;
        #1;
        chk("pre_rst_flag", bif.jump_flag_o, 1);
        chk("pre_rst_btb_vld", bif.btb_valid_o, 1);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rst_btb_vld", bif.btb_valid_o, 0);
        chk("mid_rst_flag", bif.jump_flag_o, 0);
        #5 rst_n = 1'b0;
        tick();
        chk("post_rst_ready", bif.req_ready_o, 1);
        chk("post_rst_btb_vld", bif.btb_valid_o, 0);
        chk("post_rst_flag", bif.jump_flag_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
